picomips_seq: RTL and testbench
===============================

# picomips_seq

Instruction sequencer for the picoMips core; sits directly upstream of the accumulator ALU. It fetches 16-bit instructions from a synchronous program ROM and decodes each one into the ALU and register-file control strobes. It also provides a `Go` switch handshake so programs can block on the user input. One instruction completes every two cycles unless the sequencer is waiting or halted.

## Interface
- `PW`, 8, program counter width (ROM depth 2^PW)
- `RW`, 3, register-file address width
- `Clock  in  1  system clock, rising edge`
- `nReset  in  1  reset, asynchronous, active-low`
- `Go  in  1  user handshake switch (SW8), asynchronous to Clock`
- `InstrData  in  16  ROM read data, valid one cycle after PC changes`
- `PC  out  PW  ROM address`
- `Imm  out  8  immediate to ALU, InstrData[7:0]`
- `Func  out  3  ALU function, InstrData[14:12]`
- `RegAddr  out  RW  register-file address, InstrData[8+RW-1:8]`
- `RegWE  out  1  register-file write strobe (ACC -> reg)`
- `WE  out  1  ALU accumulator write enable`
- `SelSW  out  1  ALU selects SW as operand`
- `SelImm  out  1  ALU selects Imm as operand`
- `UseMul  out  1  ALU multiply mode`
- `UseACC  out  1  ALU includes ACC in the sum`
- `Halted  out  1  sequencer halted`

## Operation
- Opcode is InstrData[15:12]. Encodings:
  - 0 NOP
  - 1 LDI: SelImm, WE
  - 2 LDSW: SelSW, WE
  - 3 LDR: WE
  - 4 ADDI: UseACC, SelImm, WE
  - 5 ADDR: UseACC, WE
  - 6 MULI: UseACC, UseMul, WE
  - 7 STR: RegWE
  - 8 JMP
  - 9 WAITH
  - A WAITL
  - B HALT
  - C–F decode as NOP.
- States: FETCH, EXEC, HALT.
- FETCH: PC stable; the ROM registers the instruction. All strobes are 0. The next state is always EXEC.
- EXEC: the instruction is decoded combinationally from InstrData. Strobes, Imm, Func and RegAddr are driven only in this state; every strobe and data output is 0 in every other state.
- PC update on leaving EXEC:
  - JMP loads PC = Imm[PW-1:0].
  - All other opcodes load PC = PC+1, wrapping modulo 2^PW (2^PW-1 → 0).
- WAITH/WAITL hold in EXEC with PC unchanged while the synchronised Go is 0 (WAITH) or 1 (WAITL). Once the condition is met: PC+1, then FETCH.
- HALT: PC frozen, Halted=1, all strobes 0. Only reset exits HALT.
- Reset (any time, including mid-EXEC or mid-wait):
  - State=FETCH, PC=0, Halted=0.
  - All strobes, Imm, Func and RegAddr = 0.
  - The synchroniser flops clear to 0.

## Timing
- Throughput: 2 cycles per non-waiting instruction. ROM latency is 1 cycle (address in FETCH, data used in EXEC).
- WE and RegWE are single-cycle pulses in EXEC. The ALU captures on the rising edge ending EXEC.
- A JMP is followed by FETCH at the target address; there is no delay slot.
- Go is sampled through the synchroniser, so a Go change is seen 2 cycles later when PICOMIPS_GO_SYNC_EN is defined, or 0 cycles later when it is not.
- The wait exit edge and the PC increment occur on the same clock edge.
- After reset release, the first FETCH presents PC=0; the first EXEC is cycle 2.

## Configuration
- `PICOMIPS_GO_SYNC_EN`
  - Defined: Go passes through a 2-flop synchroniser (reset to 0) before the wait comparison.
  - Undefined: Go is used directly. This is for simulation, or for Go already synchronous to Clock.

## Structure
- `picomips_pkg`:
  - opcode enum (4-bit)
  - state enum (FETCH/EXEC/HALT)
  - instruction field bit positions as localparams
- Sub-module `picomips_sync2`: 1-bit two-flop synchroniser with async active-low reset. It is instantiated only under PICOMIPS_GO_SYNC_EN.

## Test plan
- Reset mid-EXEC of ADDI: assert nReset low → PC=0, WE=0, Imm=0 immediately; after release, first EXEC fetches address 0.
- ROM {LDI 0x05, ADDI 0x03, STR r2, HALT}:
  - WE pulses in cycles 2 and 4 with Imm=5 then 3.
  - RegWE=1 with RegAddr=2 in cycle 6.
  - Halted=1 from cycle 8; PC stays at 3.
- JMP 0x10 at address 0 → PC=0x10 on the next FETCH. With PW=8, JMP to 0xFF followed by NOP → PC wraps to 0x00.
- WAITH with Go=0 for 10 cycles, then Go=1:
  - PC is held and all strobes are 0 during the wait.
  - PC advances exactly 2 cycles after Go rises (sync on), then the following instruction executes.
- WAITL entered with Go already 0 → no stall; behaves as a NOP.
- Every opcode C–F executes as NOP: no strobes asserted, PC+1.

Source files
------------

// File: rtl/picomips_pkg.sv
// -----------------------------------------------------------------------------
// picomips_pkg
// Shared definitions for the picoMips instruction sequencer:
//   - opcode_t : 4-bit opcode encodings (InstrData[15:12])
//   - state_t  : sequencer FSM states (FETCH / EXEC / HALT)
//   - ctrl_t   : bundle of ALU / register-file strobes
//   - instruction field bit positions
//   - decode_ctrl() : opcode -> strobe bundle
// -----------------------------------------------------------------------------
package picomips_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_LDSW  = 4'h2,
        OP_LDR   = 4'h3,
        OP_ADDI  = 4'h4,
        OP_ADDR  = 4'h5,
        OP_MULI  = 4'h6,
        OP_STR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_WAITH = 4'h9,
        OP_WAITL = 4'hA,
        OP_HALT  = 4'hB
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic reg_we;
        logic we;
        logic sel_sw;
        logic sel_imm;
        logic use_mul;
        logic use_acc;
    } ctrl_t;

    // Instruction field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int FUNC_MSB = 14;
    localparam int FUNC_LSB = 12;
    localparam int REG_LSB  = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Opcodes C..F and all control-flow opcodes produce no strobes.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_LDI:  begin c.sel_imm = 1'b1; c.we = 1'b1; end
            OP_LDSW: begin c.sel_sw  = 1'b1; c.we = 1'b1; end
            OP_LDR:  begin c.we      = 1'b1; end
            OP_ADDI: begin c.use_acc = 1'b1; c.sel_imm = 1'b1; c.we = 1'b1; end
            OP_ADDR: begin c.use_acc = 1'b1; c.we = 1'b1; end
            OP_MULI: begin c.use_acc = 1'b1; c.use_mul = 1'b1; c.we = 1'b1; end
            OP_STR:  begin c.reg_we  = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/picomips_seq_sync2.sv
// -----------------------------------------------------------------------------
// picomips_sync2
// 1-bit two-flop synchroniser with asynchronous active-low reset (flops
// clear to 0).
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronised output (2 cycles of latency)
// -----------------------------------------------------------------------------
module picomips_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/picomips_seq.sv
// -----------------------------------------------------------------------------
// picomips_seq
// Instruction sequencer for the picoMips core. Fetches 16-bit instructions
// from a synchronous ROM (one cycle latency) and decodes them into ALU and
// register-file strobes. One instruction per two cycles (FETCH, EXEC) unless
// waiting on the Go switch or halted.
//
// Configuration macro: PICOMIPS_GO_SYNC_EN
//   defined   -> Go passes through picomips_sync2 (2-cycle latency)
//   undefined -> Go is used directly in the wait comparison
//
// Parameters:
//   PW : program counter width (ROM depth 2^PW), must be <= 8 (JMP target
//        is taken from the 8-bit immediate)
//   RW : register-file address width
// Ports:
//   Clock, nReset      : clock, asynchronous active-low reset
//   Go                 : user handshake switch
//   InstrData[15:0]    : ROM read data
//   PC[PW-1:0]         : ROM address
//   Imm, Func, RegAddr : instruction fields, driven in EXEC only
//   RegWE, WE, SelSW, SelImm, UseMul, UseACC : strobes, EXEC only
//   Halted             : sequencer halted
//   o_dbg_state[1:0]   : current FSM state (state_t encoding)
//
// Handshake: WAITH stalls in EXEC while Go (after optional sync) is 0, WAITL
// while it is 1; the PC increment and the exit from EXEC happen on the same
// clock edge once the condition is satisfied.
// -----------------------------------------------------------------------------
module picomips_seq
    import picomips_pkg::*;
#(
    parameter int PW = 8,
    parameter int RW = 3
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          Go,
    input  logic [15:0]   InstrData,
    output logic [PW-1:0] PC,
    output logic [7:0]    Imm,
    output logic [2:0]    Func,
    output logic [RW-1:0] RegAddr,
    output logic          RegWE,
    output logic          WE,
    output logic          SelSW,
    output logic          SelImm,
    output logic          UseMul,
    output logic          UseACC,
    output logic          Halted,
    output logic [1:0]    o_dbg_state
);

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_pc;
    logic [PW-1:0] w_next_pc;
    logic [3:0]    w_opcode;
    logic [7:0]    w_imm;
    ctrl_t         w_ctrl;
    logic          w_go;

`ifdef PICOMIPS_GO_SYNC_EN
    picomips_sync2 u_go_sync (
        .i_clk   (Clock),
        .i_rst_n (nReset),
        .i_d     (Go),
        .o_q     (w_go)
    );
`else
    assign w_go = Go;
`endif

    assign w_opcode = InstrData[OPC_MSB:OPC_LSB];
    assign w_imm    = InstrData[IMM_MSB:IMM_LSB];

    // Instruction bits between the register field and the opcode are not
    // interpreted by any instruction.
    generate
        if (REG_LSB + RW < OPC_LSB) begin : g_spare_bits
            logic w_unused_bits;
            assign w_unused_bits = ^InstrData[OPC_LSB-1:REG_LSB+RW];
        end
    endgenerate

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_ctrl       = '0;
        Imm          = '0;
        Func         = '0;
        RegAddr      = '0;
        Halted       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_next_state = ST_EXEC;
            end

            ST_EXEC: begin
                Imm          = w_imm;
                Func         = InstrData[FUNC_MSB:FUNC_LSB];
                RegAddr      = InstrData[REG_LSB +: RW];
                w_ctrl       = decode_ctrl(w_opcode);
                w_next_state = ST_FETCH;
                w_next_pc    = r_pc + PW'(1);

                case (w_opcode)
                    OP_JMP: begin
                        w_next_pc = w_imm[PW-1:0];
                    end
                    OP_WAITH: begin
                        if (!w_go) begin
                            w_next_state = ST_EXEC;
                            w_next_pc    = r_pc;
                        end
                    end
                    OP_WAITL: begin
                        if (w_go) begin
                            w_next_state = ST_EXEC;
                            w_next_pc    = r_pc;
                        end
                    end
                    OP_HALT: begin
                        // Halted is reported already in the EXEC cycle of HALT.
                        w_next_state = ST_HALT;
                        w_next_pc    = r_pc;
                        Halted       = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_HALT: begin
                Halted = 1'b1;
            end

            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    assign PC          = r_pc;
    assign RegWE       = w_ctrl.reg_we;
    assign WE          = w_ctrl.we;
    assign SelSW       = w_ctrl.sel_sw;
    assign SelImm      = w_ctrl.sel_imm;
    assign UseMul      = w_ctrl.use_mul;
    assign UseACC      = w_ctrl.use_acc;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_picomips_seq.sv
module tb_picomips_seq;

`ifdef PICOMIPS_GO_SYNC_EN
  localparam int GO_LAT = 2;
`else
  localparam int GO_LAT = 0;
`endif
  localparam int MAXC = 256;

  // ---------------- clock / reset / DUT ----------------
  logic        Clock = 1'b0;
  logic        nReset;
  logic        Go;
  logic [15:0] InstrData;
  logic [7:0]  PC;
  logic [7:0]  Imm;
  logic [2:0]  Func;
  logic [2:0]  RegAddr;
  logic        RegWE, WE, SelSW, SelImm, UseMul, UseACC, Halted;
  logic [1:0]  dbg_state;

  always #5 Clock = ~Clock;

  picomips_seq #(.PW(8), .RW(3)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Go          (Go),
    .InstrData   (InstrData),
    .PC          (PC),
    .Imm         (Imm),
    .Func        (Func),
    .RegAddr     (RegAddr),
    .RegWE       (RegWE),
    .WE          (WE),
    .SelSW       (SelSW),
    .SelImm      (SelImm),
    .UseMul      (UseMul),
    .UseACC      (UseACC),
    .Halted      (Halted),
    .o_dbg_state (dbg_state)
  );

  // synchronous program ROM, one cycle latency
  logic [15:0] rom [256];
  always @(posedge Clock) InstrData <= rom[PC];

  // ---------------- reference model / scoreboard ----------------
  bit          go_plan [MAXC];
  logic [5:0]  strobe_tab [16];   // {RegWE,WE,SelSW,SelImm,UseMul,UseACC}
  logic [28:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [28:0] pack_vec(logic [7:0] pc, logic [7:0] imm, logic [2:0] fn,
                                           logic [2:0] ra, logic [5:0] stb, logic h);
    return {pc, imm, fn, ra, stb, h};
  endfunction

  function automatic bit go_seen(int c);
    if (c - GO_LAT < 0) return 1'b0;
    return go_plan[c - GO_LAT];
  endfunction

  // Instruction-level interpreter expanded into an expected per-cycle trace:
  // each instruction costs one fetch cycle plus one or more execute cycles.
  task automatic build_trace(input int ncyc);
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  op;
    int          c;
    bit          halted;
    bit          stall;
    exp_q.delete();
    pc = 8'd0; c = 0; halted = 1'b0;
    while (c < ncyc) begin
      if (halted) begin
        exp_q.push_back(pack_vec(pc, 8'd0, 3'd0, 3'd0, 6'd0, 1'b1));
        c++;
      end else begin
        exp_q.push_back(pack_vec(pc, 8'd0, 3'd0, 3'd0, 6'd0, 1'b0));
        c++;
        instr = rom[pc];
        op    = instr[15:12];
        stall = 1'b1;
        while (stall && c < ncyc) begin
          stall = (op == 4'h9 && !go_seen(c)) || (op == 4'hA && go_seen(c));
          exp_q.push_back(pack_vec(pc, instr[7:0], instr[14:12], instr[10:8],
                                   strobe_tab[op], op == 4'hB));
          c++;
        end
        if (!stall) begin
          if (op == 4'h8)      pc = instr[7:0];
          else if (op == 4'hB) halted = 1'b1;
          else                 pc = pc + 8'd1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    for (int c = 0; c < MAXC; c++) go_plan[c] = 1'b0;
  endtask

  task automatic apply_reset();
    nReset = 1'b0;
    Go     = 1'b0;
    repeat (2) @(posedge Clock);
    #1 nReset = 1'b1;
  endtask

  // Runs ncyc cycles from reset release; ends at the negedge of the last one.
  task automatic run_cycles(input string name, input int ncyc);
    logic [28:0] act, exp;
    build_trace(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      Go = go_plan[c];
      @(negedge Clock);
      act = {PC, Imm, Func, RegAddr, RegWE, WE, SelSW, SelImm, UseMul, UseACC, Halted};
      exp = exp_q.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: actual pc=%h imm=%h func=%h reg=%h stb=%b halt=%b, required pc=%h imm=%h func=%h reg=%h stb=%b halt=%b",
                 name, c, act[28:21], act[20:13], act[12:10], act[9:7], act[6:1], act[0],
                 exp[28:21], exp[20:13], exp[12:10], exp[9:7], exp[6:1], exp[0]);
      end
      if (c != ncyc - 1) begin
        @(posedge Clock);
        #1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [28:0] act;
    clear_rom();
    rom[0] = 16'h1055;
    nReset = 1'b0;
    Go     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      act = {PC, Imm, Func, RegAddr, RegWE, WE, SelSW, SelImm, UseMul, UseACC, Halted};
      n_cmp++;
      if (act !== 29'd0) begin
        n_err++;
        $display("FAIL reset_outputs sample %0d: actual %h required 0", i, act);
      end
      Go = ~Go;
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    rom[0] = 16'h0000;       // NOP
    rom[1] = 16'h4007;       // ADDI 7
    rom[2] = 16'h1003;
    apply_reset();
    run_cycles("mid_exec_pre", 4);   // now in EXEC of ADDI at PC=1
    nReset = 1'b0;
    #1;
    n_cmp++;
    if (PC !== 8'd0) begin n_err++; $display("FAIL mid_exec_reset_pc: actual %h required 00", PC); end
    n_cmp++;
    if (WE !== 1'b0) begin n_err++; $display("FAIL mid_exec_reset_we: actual %b required 0", WE); end
    n_cmp++;
    if (Imm !== 8'd0) begin n_err++; $display("FAIL mid_exec_reset_imm: actual %h required 00", Imm); end
    apply_reset();
    run_cycles("mid_exec_post", 6);
  endtask

  task automatic test_program_halt();
    clear_rom();
    rom[0] = 16'h1005;       // LDI 5
    rom[1] = 16'h4003;       // ADDI 3
    rom[2] = 16'h7200;       // STR r2
    rom[3] = 16'hB000;       // HALT
    apply_reset();
    run_cycles("halt_prog", 14);
  endtask

  task automatic test_jmp_wrap();
    clear_rom();
    rom[8'h00] = 16'h8010;   // JMP 0x10
    rom[8'h10] = 16'h6021;   // MULI
    rom[8'h11] = 16'h80FF;   // JMP 0xFF
    rom[8'hFF] = 16'h0000;   // NOP -> wraps to 0
    apply_reset();
    run_cycles("jmp_wrap", 14);
  endtask

  task automatic test_waith();
    clear_rom();
    rom[0] = 16'h9000;       // WAITH
    rom[1] = 16'h1042;       // LDI 0x42
    rom[2] = 16'hB000;
    for (int c = 12; c < MAXC; c++) go_plan[c] = 1'b1;
    apply_reset();
    run_cycles("waith", 24);
  endtask

  task automatic test_waitl_nostall();
    clear_rom();
    rom[0] = 16'hA000;       // WAITL with Go low: no stall
    rom[1] = 16'h2300;       // LDSW
    rom[2] = 16'h3500;       // LDR r5
    rom[3] = 16'h5100;       // ADDR r1
    rom[4] = 16'hB000;
    apply_reset();
    run_cycles("waitl_nostall", 12);
  endtask

  task automatic test_nop_opcodes();
    clear_rom();
    rom[0] = 16'hC123;
    rom[1] = 16'hD456;
    rom[2] = 16'hE789;
    rom[3] = 16'hFABC;
    rom[4] = 16'hB000;
    apply_reset();
    run_cycles("nop_cf", 12);
  endtask

  task automatic test_random();
    logic [3:0] op;
    bit         g;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 256; a++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hB && $urandom_range(0, 3) != 0) op = 4'h0;
        rom[a] = {op, 12'($urandom)};
      end
      g = 1'($urandom_range(0, 1));
      for (int c = 0; c < MAXC; c++) begin
        if ($urandom_range(0, 5) == 0) g = ~g;
        go_plan[c] = g;
      end
      apply_reset();
      run_cycles("random", 60);
    end
  endtask

  initial begin
    strobe_tab[0]  = 6'b000000;
    strobe_tab[1]  = 6'b010100;  // LDI  : WE SelImm
    strobe_tab[2]  = 6'b011000;  // LDSW : WE SelSW
    strobe_tab[3]  = 6'b010000;  // LDR  : WE
    strobe_tab[4]  = 6'b010101;  // ADDI : WE SelImm UseACC
    strobe_tab[5]  = 6'b010001;  // ADDR : WE UseACC
    strobe_tab[6]  = 6'b010011;  // MULI : WE UseMul UseACC
    strobe_tab[7]  = 6'b100000;  // STR  : RegWE
    for (int o = 8; o < 16; o++) strobe_tab[o] = 6'b000000;

    nReset = 1'b0;
    Go     = 1'b0;
    test_reset();
    test_reset_mid_exec();
    test_program_halt();
    test_jmp_wrap();
    test_waith();
    test_waitl_nostall();
    test_nop_opcodes();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
